// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with ALU-op decode, EX/MEM and MEM/WB
//               operand forwarding, and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [1:0]        id_alu_class,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] store_data,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_illegal,
    output logic              load_use_hazard
);

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_cmp = 4'b0101;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_nor = 4'b1100;

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_branch;
    logic              r_alu_src;
    logic              r_illegal;
    logic [3:0]        r_alu_op;
    logic [REG_W-1:0]  r_write_reg;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;

    logic [3:0]        w_alu_op;
    logic              w_illegal;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    always_comb begin
        w_alu_op  = c_alu_add;
        w_illegal = 1'b0;
        case (id_alu_class)
            2'b00:   w_alu_op = c_alu_add;
            2'b01:   w_alu_op = c_alu_cmp;
            2'b11:   w_alu_op = c_alu_or;
            default: begin
                case (id_funct)
                    6'b100000: w_alu_op = c_alu_add;
                    6'b100010: w_alu_op = c_alu_sub;
                    6'b100100: w_alu_op = c_alu_and;
                    6'b100101: w_alu_op = c_alu_or;
                    6'b100111: w_alu_op = c_alu_nor;
                    6'b101010: w_alu_op = c_alu_slt;
                    default: begin
                        w_alu_op  = c_alu_add;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // An invalid ID slot is captured exactly like a flush bubble.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !id_valid)) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_alu_src    <= 1'b0;
            r_illegal    <= 1'b0;
            r_alu_op     <= 4'b0000;
            r_write_reg  <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_branch     <= id_branch;
            r_alu_src    <= id_alu_src;
            r_illegal    <= w_illegal;
            r_alu_op     <= w_alu_op;
            r_write_reg  <= id_reg_dst ? id_rd : id_rt;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
        end
    end

    // The younger EX/MEM result shadows MEM/WB; register 0 always reads its own data.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_W-1:0]  idx,
        input logic [DATA_W-1:0] reg_val,
        input logic              em_we,
        input logic [REG_W-1:0]  em_rd,
        input logic [DATA_W-1:0] em_val,
        input logic              mw_we,
        input logic [REG_W-1:0]  mw_rd,
        input logic [DATA_W-1:0] mw_val
    );
        if (em_we && (em_rd != '0) && (em_rd == idx))
            return em_val;
        else if (mw_we && (mw_rd != '0) && (mw_rd == idx))
            return mw_val;
        else
            return reg_val;
    endfunction

    assign w_fwd_rs = fwd_sel(r_rs, r_rs_data, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);
    assign w_fwd_rt = fwd_sel(r_rt, r_rt_data, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);

    assign alu_a         = w_fwd_rs;
    assign store_data    = w_fwd_rt;
    assign alu_b         = r_alu_src ? r_imm : w_fwd_rt;
    assign alu_op        = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_write_reg  = r_write_reg;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_branch     = r_branch;
    assign ex_illegal    = r_illegal;

    assign load_use_hazard = r_valid & r_mem_read & (r_write_reg != '0) &
                             ((r_write_reg == id_rs) | (r_write_reg == id_rt));

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID and decodes the 2-bit main-control ALU class plus funct into the 4-bit ALU opcode.
- Applies EX/MEM and MEM/WB forwarding to produce the final ALU A/B operands.
- Flags load-use hazards back to the hazard unit.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-index width

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  hold current contents
flush  in  1  load a bubble on next edge
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_W  register indices
id_alu_class  in  2  00 add, 01 branch-compare, 10 R-type, 11 or-immediate
id_funct  in  6  instruction funct field
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  main-control bits
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM value
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB value
alu_a, alu_b  out  DATA_W  ALU operands
alu_op  out  4  ALU opcode
store_data  out  DATA_W  forwarded rt value for stores
ex_valid  out  1  EX holds a real instruction
ex_write_reg  out  REG_W  destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
ex_illegal  out  1  unsupported R-type funct
load_use_hazard  out  1  stall request to ID

Behaviour:
- Clock and reset: single clock clk, rising edge. rst is synchronous and active-high.
- Reset clears every register to 0, so ex_valid=0, all control outputs=0 and alu_op=0000.
- Capture rules at each edge, highest priority first:
  - rst clears all registers.
  - flush loads a bubble: ex_valid and every control bit 0, ex_illegal=0, data/index registers 0.
  - stall holds all registers.
  - Otherwise registers load from id_*. If id_valid=0, the loaded entry is a bubble.
- Latency: 1 cycle, ID to EX.
- Registered fields:
  - ex_write_reg = id_reg_dst ? id_rd : id_rt.
  - alu_src, imm, rs, rt and both data words are also registered.
- alu_op decode, performed at capture and registered:
  - class 00 -> 0010; class 01 -> 0101; class 11 -> 0001.
  - class 10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100, 101010 -> 0111.
  - Any other funct -> 0010 with ex_illegal=1.
- Forwarding is combinational from the registered rs/rt, applied to A and to the rt value separately:
  - Use EX/MEM if exmem_reg_write, exmem_rd != 0 and exmem_rd matches.
  - Else use MEM/WB if memwb_reg_write, memwb_rd != 0 and memwb_rd matches.
  - Else use the registered data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand selection:
  - alu_a = forwarded rs value.
  - store_data = forwarded rt value.
  - alu_b = alu_src ? registered imm : forwarded rt value.
- load_use_hazard (combinational) = ex_valid & ex_mem_read & ex_write_reg != 0 & (ex_write_reg == id_rs | ex_write_reg == id_rt). It is high regardless of id_valid.
- During stall, outputs keep being driven from held registers, and forwarding keeps tracking the live exmem/memwb inputs.
- flush asserted together with stall produces a bubble; flush wins.
- rst asserted together with flush or stall yields the reset state.

Test Plan:
- Reset: rst=1 for 2 edges with id_valid=1, id_reg_write=1 -> ex_valid=0, ex_reg_write=0, alu_op=0000, load_use_hazard=0.
- R-type decode: class 10, funct 101010, rs_data=5, rt_data=9, no forward -> next cycle alu_op=0111, alu_a=5, alu_b=9, ex_illegal=0. Then funct 000000 -> alu_op=0010, ex_illegal=1.
- Forward priority: EX rs=3, exmem_rd=3/result=0xAA, memwb_rd=3/result=0xBB, both writing -> alu_a=0xAA. Drop exmem_reg_write -> alu_a=0xBB. Set rs=0 with both rd=0 -> registered data, no forward.
- Immediate path: class 00, alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x10 -> alu_b=0xFFFFFFFC, store_data=0x10, alu_op=0010.
- Load-use: EX holds lw with ex_write_reg=7, ID presents id_rt=7 -> load_use_hazard=1. Assert stall one edge -> outputs unchanged. Then flush -> ex_valid=0, ex_mem_read=0, hazard=0.
- Flush beats stall: stall=1, flush=1 with a valid sw in EX -> next cycle ex_mem_write=0, ex_valid=0.
